// File: rtl/noc_vc_input_buffer_if.sv
// Handshake bundle between upstream link, VC input buffer and
// route stage.
interface noc_vc_input_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int TGT_W  = 3,
  parameter int NUM_VC = 2,
  parameter int DEPTH  = 8
);
  localparam int FLIT_W = DATA_W + ADDR_W + TGT_W;
  localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [FLIT_W-1:0]        in_flit;
  logic                     in_valid;
  logic [VC_W-1:0]          in_vc;
  logic                     pop;
  logic [VC_W-1:0]          pop_vc;
  logic [NUM_VC*FLIT_W-1:0] out_flit;
  logic [NUM_VC-1:0]        out_valid;
  logic [NUM_VC*CNT_W-1:0]  count;
  logic                     credit_valid;
  logic [VC_W-1:0]          credit_vc;
  logic                     overflow_err;
  logic                     underflow_err;
  logic                     err_clr;

  modport master (
    output in_flit, in_valid, in_vc,
    output pop, pop_vc, err_clr,
    input  out_flit, out_valid, count,
    input  credit_valid, credit_vc,
    input  overflow_err, underflow_err
  );

  modport slave (
    input  in_flit, in_valid, in_vc,
    input  pop, pop_vc, err_clr,
    output out_flit, out_valid, count,
    output credit_valid, credit_vc,
    output overflow_err, underflow_err
  );
endinterface

// File: rtl/noc_vc_input_buffer.sv
// Router input buffer: per-VC circular FIFOs with parallel head
// visibility, registered credit return and sticky error flags.
module noc_vc_input_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int TGT_W  = 3,
  parameter int NUM_VC = 2,
  parameter int DEPTH  = 8
) (
  input logic clk,
  input logic rst,
  noc_vc_input_buffer_if.slave bus
);
  localparam int FLIT_W = DATA_W + ADDR_W + TGT_W;
  localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem    [NUM_VC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_VC];
  logic [PTR_W-1:0]  rd_ptr [NUM_VC];
  logic [CNT_W-1:0]  cnt    [NUM_VC];

  logic [NUM_VC-1:0] wr_req;
  logic [NUM_VC-1:0] wr_hit;
  logic [NUM_VC-1:0] pop_hit;
  logic              in_ok;
  logic              pop_ok;
  logic              ovf_ev;
  logic              unf_ev;
  logic              credit_valid_q;
  logic [VC_W-1:0]   credit_vc_q;
  logic              ovf_q;
  logic              unf_q;

  logic [NUM_VC*FLIT_W-1:0] head;
  logic [NUM_VC*CNT_W-1:0]  cnt_flat;
  logic [NUM_VC-1:0]        nonempty;

  assign in_ok  = 32'(bus.in_vc) < NUM_VC;
  assign pop_ok = 32'(bus.pop_vc) < NUM_VC;

  // Full is judged after a same-VC pop; empty is never rescued.
  always_comb begin
    wr_req  = '0;
    wr_hit  = '0;
    pop_hit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      pop_hit[v] = bus.pop && pop_ok &&
                   bus.pop_vc == VC_W'(v) &&
                   cnt[v] != '0;
      wr_req[v]  = bus.in_valid && in_ok &&
                   bus.in_vc == VC_W'(v);
      wr_hit[v]  = wr_req[v] &&
                   (cnt[v] != CNT_W'(DEPTH) || pop_hit[v]);
    end
  end

  assign ovf_ev = bus.in_valid &&
                  (!in_ok || |(wr_req & ~wr_hit));
  assign unf_ev = bus.pop && !(|pop_hit);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_hit[v])
          mem[v][wr_ptr[v]] <= bus.in_flit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        cnt[v]    <= '0;
      end
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      ovf_q          <= 1'b0;
      unf_q          <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_hit[v])
          wr_ptr[v] <= wr_ptr[v] + 1'b1;
        if (pop_hit[v])
          rd_ptr[v] <= rd_ptr[v] + 1'b1;
        if (wr_hit[v] && !pop_hit[v])
          cnt[v] <= cnt[v] + 1'b1;
        else if (!wr_hit[v] && pop_hit[v])
          cnt[v] <= cnt[v] - 1'b1;
      end
      credit_valid_q <= |pop_hit;
      credit_vc_q    <= (|pop_hit) ? bus.pop_vc : '0;
      // A fresh error beats a same-cycle clear.
      if (ovf_ev)
        ovf_q <= 1'b1;
      else if (bus.err_clr)
        ovf_q <= 1'b0;
      if (unf_ev)
        unf_q <= 1'b1;
      else if (bus.err_clr)
        unf_q <= 1'b0;
    end
  end

  always_comb begin
    head     = '0;
    cnt_flat = '0;
    nonempty = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      nonempty[v] = cnt[v] != '0;
      cnt_flat[v*CNT_W +: CNT_W] = cnt[v];
      if (cnt[v] != '0)
        head[v*FLIT_W +: FLIT_W] = mem[v][rd_ptr[v]];
    end
  end

  assign bus.out_flit      = head;
  assign bus.out_valid     = nonempty;
  assign bus.count         = cnt_flat;
  assign bus.credit_valid  = credit_valid_q;
  assign bus.credit_vc     = credit_vc_q;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;
endmodule

// File: doc/noc_vc_input_buffer.md
Name: noc_vc_input_buffer

Overview:
Next-generation router input buffer. Holds incoming flits in NUM_VC independent virtual-channel FIFOs. Each FIFO uses circular read/write pointers instead of a shift register. Exposes every VC's head flit in parallel to the route/arbitration stage, returns a credit per popped flit to the upstream router, and reports overflow/underflow as sticky errors instead of clearing the buffer.

Parameters:
DATA_W, 16, payload field width
ADDR_W, 4, address field width
TGT_W, 3, target field width
FLIT_W, DATA_W+ADDR_W+TGT_W (23), derived flit width; layout {data, addr, target}, target in LSBs
NUM_VC, 2, number of virtual channels (>=1)
DEPTH, 8, entries per VC; power of two, >=2
VC_W, max(1,clog2(NUM_VC)), derived VC index width
CNT_W, clog2(DEPTH+1), derived occupancy width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
in_flit  in  FLIT_W  write data
in_valid  in  1  write request
in_vc  in  VC_W  destination VC of write
pop  in  1  pop request
pop_vc  in  VC_W  VC to pop
out_flit  out  NUM_VC*FLIT_W  head flit per VC; VC v at [v*FLIT_W +: FLIT_W]
out_valid  out  NUM_VC  bit v = VC v non-empty
count  out  NUM_VC*CNT_W  occupancy per VC; VC v at [v*CNT_W +: CNT_W]
credit_valid  out  1  one credit returned this cycle
credit_vc  out  VC_W  VC of returned credit
overflow_err  out  1  sticky: write to a full VC was dropped
underflow_err  out  1  sticky: pop of an empty VC was ignored
err_clr  in  1  clears both sticky errors

Behaviour:
- Reset (rst=1 at clk edge): all pointers and counts = 0, out_valid = 0, out_flit = 0, credit_valid = 0, credit_vc = 0, both errors = 0. Storage contents need not be cleared. Reset overrides all same-cycle requests.
- Per VC: wr_ptr and rd_ptr, each clog2(DEPTH) bits, wrap naturally modulo DEPTH; count in 0..DEPTH.
- Write accepted when in_valid=1 and VC in_vc is not full, or is full but pop=1 with pop_vc==in_vc in the same cycle. Accepted write stores at wr_ptr, then wr_ptr+1.
- Pop accepted when pop=1 and VC pop_vc has count>0. Accepted pop advances rd_ptr.
- Decisions use start-of-cycle counts. Full is judged after same-cycle pop on the same VC; empty is not rescued by a same-cycle write.
- Count update per VC: +1 on write only, -1 on pop only, unchanged on both or neither.
- Head visibility: out_flit[v] = storage[v][rd_ptr]. A write to an empty VC appears on out_flit/out_valid one cycle after the write edge, giving 1-cycle latency. After a pop the next entry is visible in the following cycle. out_flit[v] is forced to 0 while VC v is empty.
- Dropped write (full, no same-VC pop): storage, pointers and count unchanged; overflow_err set next cycle.
- Ignored pop (empty VC): no state change, no credit; underflow_err set next cycle.
- Out-of-range VC index (in_vc or pop_vc >= NUM_VC): request ignored and the matching error flag set.
- Credits: each accepted pop gives credit_valid=1 with credit_vc=pop_vc on the next cycle (registered), otherwise credit_valid=0. At most one credit per cycle.
- Errors: sticky until err_clr=1. If err_clr and a new error occur in the same cycle, the error wins and the flag stays 1.
- Write and pop on different VCs in the same cycle are fully independent.

Test Plan:
1. Reset, then write flits 0x000001..0x000003 to VC0 on consecutive cycles -> out_valid=01 one cycle after first write, count0=3, out_flit VC0=0x000001; three pops -> heads 0x000002, 0x000003, then out_valid=00, out_flit VC0=0, three credits credit_vc=0.
2. Fill VC1 with 8 flits, 9th write with no pop -> count1 stays 8, overflow_err=1, contents intact; pop 8 times -> original order returned; err_clr -> overflow_err=0.
3. VC0 full (8 entries), write 0x7FFFFF and pop VC0 in the same cycle -> write accepted, count0 stays 8, no overflow_err, 0x7FFFFF is the last flit popped.
4. Write VC0 while popping VC1 (count1=2) in the same cycle -> count0+1, count1=1, credit_vc=1 on next cycle.
5. Pop empty VC1 -> underflow_err=1, credit_valid=0; 20+ push/pop cycles on VC0 to wrap pointers -> data order preserved across wrap.
6. Assert rst mid-stream with VC0 count=5 -> next cycle all counts 0, out_valid=00, credit_valid=0, errors 0.
